// File: rtl/comm_transmitter.sv
// Framed, CRC-32-protected byte serializer driving the 14-bit comm DAC.
// Each byte becomes a 10-bit symbol; each bit is a BIT_TICKS slope pulse.
module comm_transmitter #(
  parameter int BIT_TICKS   = 20,
  parameter int PULSE_TICKS = 8,
  parameter int HIGH_LEVEL  = 14000,
  parameter int LOW_LEVEL   = 2000,
  parameter int GAP_TICKS   = 60,
  parameter int MAX_BYTES   = 1024
) (
  input  logic        inclk,
  input  logic        reset,
  input  logic        tx_start,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        data_last,
  output logic        data_ready,
  output logic [13:0] com_dac,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic [2:0]  dbg_state
);

  localparam int TICK_W = $clog2(BIT_TICKS + 1);
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);
  localparam int CNT_W  = $clog2(MAX_BYTES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_BYTES);
  localparam logic [13:0] HIGH_C = 14'(HIGH_LEVEL);
  localparam logic [13:0] LOW_C  = 14'(LOW_LEVEL);
  localparam logic [9:0] START_SYM = 10'b0111000111;
  localparam logic [9:0] STOP_SYM  = 10'b0100110011;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_CRC   = 3'd3,
    S_STOP  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  // Symbol bit i is sent at bit slot i: slot 0 = 1, slots 1..8 = byte MSB first, slot 9 = 0.
  function automatic logic [9:0] frame_byte(input logic [7:0] b);
    return {1'b0, b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7], 1'b1};
  endfunction

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C11DB7 : 32'h0);
  endfunction

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [3:0]         bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [1:0]         crc_sym_q, crc_sym_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;
  logic [31:0]        crc_q, crc_d;
  logic [13:0]        com_dac_q, com_dac_d;
  logic [9:0]         cur_frame;
  logic [9:0]         tx_sym;
  logic               sym_end;

  // Byte handshake: data_ready is a single-cycle request on the last tick of a
  // START/DATA symbol; data_valid is sampled in that same cycle, and if low the
  // frame is closed with an underrun and a bare stop symbol.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    byte_cnt_d = byte_cnt_q;
    crc_sym_d  = crc_sym_q;
    data_d     = data_q;
    last_d     = last_q;
    crc_d      = crc_q;
    data_ready = 1'b0;
    underrun   = 1'b0;
    done       = 1'b0;
    cur_frame  = frame_byte(data_q);
    sym_end    = (tick_q == TICK_LAST) && (bit_q == 4'd9);

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          state_d    = S_START;
          tick_d     = '0;
          bit_d      = 4'd0;
          crc_d      = 32'h0;
          byte_cnt_d = '0;
          last_d     = 1'b0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          done    = 1'b1;
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          bit_d  = (bit_q == 4'd9) ? 4'd0 : bit_q + 4'd1;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
        if (state_q == S_DATA && tick_q == '0 && bit_q >= 4'd1 && bit_q <= 4'd8)
          crc_d = crc_step(crc_q, cur_frame[bit_q]);
        if (sym_end) begin
          case (state_q)
            S_START, S_DATA: begin
              if (state_q == S_DATA && last_q) begin
                state_d   = S_CRC;
                crc_sym_d = 2'd0;
              end else begin
                data_ready = 1'b1;
                if (data_valid) begin
                  data_d     = data_in;
                  byte_cnt_d = byte_cnt_q + CNT_W'(1);
                  last_d     = data_last || (byte_cnt_q + CNT_W'(1) == CNT_MAX);
                  state_d    = S_DATA;
                end else begin
                  underrun = 1'b1;
                  state_d  = S_STOP;
                end
              end
            end
            S_CRC: begin
              // The next CRC byte is always crc[31:24]; four shifts also clear it.
              crc_d = {crc_q[23:0], 8'h00};
              if (crc_sym_q == 2'd3) state_d = S_STOP;
              else crc_sym_d = crc_sym_q + 2'd1;
            end
            S_STOP: begin
              state_d = S_GAP;
              gap_d   = '0;
            end
            default: ;
          endcase
        end
      end
    endcase

    // The DAC register is loaded with the level for the upcoming tick.
    case (state_d)
      S_START: tx_sym = START_SYM;
      S_DATA:  tx_sym = frame_byte(data_d);
      S_CRC:   tx_sym = frame_byte(crc_d[31:24]);
      S_STOP:  tx_sym = STOP_SYM;
      default: tx_sym = 10'b0;
    endcase
    com_dac_d = (tx_sym[bit_d] && tick_d < TICK_W'(PULSE_TICKS)) ? HIGH_C : LOW_C;
  end

  always_ff @(posedge inclk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= 4'd0;
      gap_q      <= '0;
      byte_cnt_q <= '0;
      crc_sym_q  <= 2'd0;
      data_q     <= 8'h00;
      last_q     <= 1'b0;
      crc_q      <= 32'h0;
      com_dac_q  <= LOW_C;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      byte_cnt_q <= byte_cnt_d;
      crc_sym_q  <= crc_sym_d;
      data_q     <= data_d;
      last_q     <= last_d;
      crc_q      <= crc_d;
      com_dac_q  <= com_dac_d;
    end
  end

  assign com_dac   = com_dac_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/comm_transmitter.md
# comm_transmitter

Serializes a byte stream into one framed, CRC-32-protected packet on the 14-bit communication DAC. It is the transmit end of the comm link that `comm_receiver` decodes. Each bit is a 20-tick slope symbol, and each 10-bit symbol carries one byte. The block sits between the packet source (a byte FIFO or the command engine) and the DAC driving the cable.

## Interface
- `BIT_TICKS`, 20: `inclk` cycles per bit.
- `PULSE_TICKS`, 8: high-level ticks at the start of a '1' bit.
- `HIGH_LEVEL`, 14000: DAC code for a pulse. Must be ≥ 12000 so the receiver selects the strong slope threshold.
- `LOW_LEVEL`, 2000: DAC code for baseline. Must be < 9216, the receiver trigger level.
- `GAP_TICKS`, 60: minimum `LOW_LEVEL` hold after the stop symbol.
- `MAX_BYTES`, 1024: payload length limit. The last allowed byte is forced to be last.
- `inclk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `tx_start`, in, 1: one-cycle request to begin a frame. Ignored while `busy`=1.
- `data_in`, in, 8: payload byte.
- `data_valid`, in, 1: `data_in` is valid.
- `data_last`, in, 1: the byte presented is the final payload byte.
- `data_ready`, out, 1: single-cycle byte request.
- `com_dac`, out, 14: DAC code.
- `busy`, out, 1: frame in progress, including the gap.
- `done`, out, 1: one-cycle pulse at the end of the frame.
- `underrun`, out, 1: one-cycle pulse when `data_valid`=0 at a request.

## Operation
- Symbol format: 10 bits sent index 0 first. Index 0 = 1 and index 9 = 0 are framing bits. Indices 1..8 carry data MSB-first (data[7] at index 1).
- Start symbol = 10'b0111000111. Stop symbol = 10'b0100110011. Both are sent index 0 first, with no CRC contribution.
- Bit waveform at bit tick t = 0..BIT_TICKS-1:
  - '1': `HIGH_LEVEL` for t < PULSE_TICKS, otherwise `LOW_LEVEL`.
  - '0': `LOW_LEVEL` for the whole bit.
- Frame sequence: start symbol, payload symbols, 4 CRC symbols, stop symbol, gap.
- CRC-32 parameters: poly 0x04C11DB7, init 0, no reflection, no final XOR.
  - Updated with each payload data bit (indices 1..8 only) at bit tick 0 of that bit.
  - CRC bytes are sent crc[31:24] first, each MSB-first in indices 1..8. CRC bits are not fed back into the CRC.
  - Result: the receiver remainder is 0 after the last CRC bit.
- States and transitions:
  - IDLE: `tx_start` → START.
  - START: after 10 bits → DATA, or → STOP on underrun.
  - DATA: after 10 bits → DATA or CRC.
  - CRC: after 4 symbols → STOP.
  - STOP: after 10 bits → GAP.
  - GAP: after `GAP_TICKS` → IDLE.
- Byte handshake: `data_ready`=1 on the final cycle of the START symbol and of each DATA symbol whose byte was not last.
  - If `data_valid`=1 in that cycle, the byte is loaded and `data_last` is captured.
  - If the captured `data_last`=1, or this is byte number `MAX_BYTES`, the next symbol after this byte is CRC.
  - If `data_valid`=0 in that cycle: `underrun` pulses, CRC is skipped, and the next symbol is STOP.
  - A zero-byte frame is therefore an underrun at the end of START.
- `data_ready` is 0 in every other cycle, including IDLE.
- `reset` mid-frame: all outputs return to their reset values on the next cycle. The CRC clears and the state returns to IDLE. No stop symbol is sent.
- `tx_start` coinciding with `done` is ignored; `busy` is still 1 in that cycle.

## Timing
- Reset values: `com_dac`=`LOW_LEVEL`, `busy`=0, `data_ready`=0, `done`=0, `underrun`=0.
- `tx_start` sampled high in cycle 0:
  - `busy`=1 and `com_dac`=`HIGH_LEVEL` from cycle 1. This is the start symbol bit 0, tick 0.
- Symbol length is 10·BIT_TICKS cycles, which is 200 at defaults.
- First `data_ready` is at cycle 200.
- Frame of N bytes, no underrun:
  - Stop symbol ends at cycle (N+6)·200.
  - `done` pulses at cycle (N+6)·200 + GAP_TICKS.
  - `busy`=0 from the following cycle.
- `com_dac` is registered. Each level change lands exactly on its bit-tick boundary, with no glitch cycles.

## Test plan
- **Single byte 0xA5, `data_last`=1:**
  - The DAC trace decodes to start, 10'b0101001011, the CRC of 0xA5 (4 symbols), then stop.
  - `done` pulses at cycle 1460 after `tx_start`.
  - Looped into `comm_receiver`: `decoding_failed`=0.
- **Payload "123456789" (9 bytes):**
  - The CRC symbols carry 0x89, 0xA1, 0x89, 0x7F.
  - The receiver CRC remainder is 0.
  - Total frame is 3000 cycles plus the gap.
- **Underrun, `data_valid`=0 at the first request:**
  - `underrun` pulses at cycle 200.
  - The stop symbol follows immediately.
  - `done` pulses at cycle 400 + GAP_TICKS.
- **Back-to-back frames (`tx_start` with `done`, then one cycle later):**
  - The first request is ignored.
  - The second starts the next frame.
  - `com_dac` stays at `LOW_LEVEL` for ≥ `GAP_TICKS` between frames.
- **`reset` asserted at cycle 450 of a frame:**
  - Next cycle: `com_dac`=`LOW_LEVEL`, `busy`=0.
  - A following 0x00 frame has correct CRC 0x00000000, and the symbols decode cleanly.
- **`MAX_BYTES`=4 with `data_last` never asserted:**
  - CRC symbols follow the 4th byte.
  - There is no 5th `data_ready`.
